iq_corr_accum: RTL and testbench

Streaming complex correlator for the beamforming weight path. It consumes paired 16-bit IQ samples: the input sample x and the reference r, in the same format the MATLAB vector files carry. Over each block of 2**LOG2_N beats it accumulates x·conj(r) and emits one 64-bit I/Q weight pair per block. It sits directly downstream of the IQ sample source and feeds the weight sink that dumps weight pairs back to MATLAB.

---
 rtl/iq_corr_pkg.sv | 36 +++
 rtl/iq_corr_accum_cmac_conj.sv | 50 +++++
 rtl/iq_corr_accum.sv | 152 +++++++++++++++
 tb/tb_iq_corr_accum.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_corr_pkg.sv
// Shared types and helpers for the iq_corr_accum streaming complex correlator.
// Optional build macro IQCORR_NORM_EN is consumed by the top level, not here.
package iq_corr_pkg;

    typedef logic signed [15:0] iq_t;

    typedef struct packed {
        iq_t i;
        iq_t q;
    } cplx_t;

    typedef logic signed [32:0] prod_t;
    typedef logic signed [63:0] weight_t;

    typedef struct packed {
        weight_t i;
        weight_t q;
    } wpair_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic weight_t widen(input prod_t p);
        return weight_t'(p);
    endfunction

    // Block mean with round-half-up; a shift of zero passes the sum through.
    function automatic weight_t norm_mean(input weight_t s, input int unsigned sh);
        weight_t rnd;
        rnd = (sh == 0) ? '0 : (weight_t'(1) <<< (sh - 1));
        return (s + rnd) >>> sh;
    endfunction

endpackage

// File: rtl/iq_corr_accum_cmac_conj.sv
// Two-stage registered complex multiply x*conj(r): input register, then product register.
// Both stages freeze while i_hold is asserted so an in-flight beat survives a stall.
module cmac_conj
    import iq_corr_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  logic  i_hold,
    input  cplx_t i_x,
    input  cplx_t i_r,
    output prod_t o_re,
    output prod_t o_im
);

    cplx_t r_x;
    cplx_t r_r;
    prod_t r_re;
    prod_t r_im;
    prod_t w_re;
    prod_t w_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_r <= '0;
        end else if (i_en) begin
            r_x <= i_x;
            r_r <= i_r;
        end
    end

    // Operands are sign-extended to 33 bits first so the sum cannot wrap.
    assign w_re = prod_t'(r_x.i) * prod_t'(r_r.i) + prod_t'(r_x.q) * prod_t'(r_r.q);
    assign w_im = prod_t'(r_x.q) * prod_t'(r_r.i) - prod_t'(r_x.i) * prod_t'(r_r.q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re <= '0;
            r_im <= '0;
        end else if (!i_hold) begin
            r_re <= w_re;
            r_im <= w_im;
        end
    end

    assign o_re = r_re;
    assign o_im = r_im;

endmodule

// File: rtl/iq_corr_accum.sv
// Streaming complex correlator: accumulates x*conj(r) over 2**LOG2_N beats and emits one weight pair.
// Build macro IQCORR_NORM_EN: output the rounded block mean instead of the raw sum.
module iq_corr_accum
    import iq_corr_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] s_xi,
    input  logic signed [15:0] s_xq,
    input  logic signed [15:0] s_ri,
    input  logic signed [15:0] s_rq,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [63:0] m_wi,
    output logic signed [63:0] m_wq,
    output slot_state_t        o_dbg_slot
);

    localparam int CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

    // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
    // valid never depends on ready, and a held weight stays stable until it transfers.

    logic [CNT_W-1:0] r_cnt;
    logic             r_v0, r_f0, r_l0;
    logic             r_p_valid, r_p_first, r_p_last;
    wpair_t           r_acc;
    wpair_t           r_slot;
    slot_state_t      r_state;
    slot_state_t      w_state_nxt;

    logic   w_stall;
    logic   w_accept;
    logic   w_first;
    logic   w_last;
    logic   w_consume;
    logic   w_write;
    cplx_t  w_x;
    cplx_t  w_r;
    prod_t  w_p_re;
    prod_t  w_p_im;
    wpair_t w_p;
    wpair_t w_sum;
    wpair_t w_out;

    assign w_x = '{i: s_xi, q: s_xq};
    assign w_r = '{i: s_ri, q: s_rq};

    assign w_stall  = r_p_valid & r_p_last & (r_state == FULL) & ~m_ready;
    assign s_ready  = ~w_stall & ~clr;
    assign w_accept = s_valid & s_ready;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    cmac_conj u_cmac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_accept),
        .i_hold (w_stall),
        .i_x    (w_x),
        .i_r    (w_r),
        .o_re   (w_p_re),
        .o_im   (w_p_im)
    );

    // Tags travel alongside the multiplier's two register stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0      <= 1'b0;
            r_f0      <= 1'b0;
            r_l0      <= 1'b0;
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
        end else if (clr) begin
            r_v0      <= 1'b0;
            r_p_valid <= 1'b0;
        end else if (!w_stall) begin
            r_v0      <= w_accept;
            r_f0      <= w_first;
            r_l0      <= w_last;
            r_p_valid <= r_v0;
            r_p_first <= r_f0;
            r_p_last  <= r_l0;
        end
    end

    assign w_p.i     = widen(w_p_re);
    assign w_p.q     = widen(w_p_im);
    assign w_sum.i   = r_p_first ? w_p.i : r_acc.i + w_p.i;
    assign w_sum.q   = r_p_first ? w_p.q : r_acc.q + w_p.q;
    assign w_consume = r_p_valid & ~w_stall;
    assign w_write   = w_consume & r_p_last;

`ifdef IQCORR_NORM_EN
    assign w_out.i = norm_mean(w_sum.i, LOG2_N);
    assign w_out.q = norm_mean(w_sum.q, LOG2_N);
`else
    assign w_out = w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_consume) begin
            r_acc <= w_sum;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_write) w_state_nxt = FULL;
            FULL:  if (m_ready && !w_write) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_write) begin
                r_slot <= w_out;
            end
        end
    end

    assign m_valid    = (r_state == FULL);
    assign m_wi       = r_slot.i;
    assign m_wq       = r_slot.q;
    assign o_dbg_slot = r_state;

endmodule

// File: tb/tb_iq_corr_accum.sv
// Directed bench for iq_corr_accum with LOG2_N=2; expectations follow IQCORR_NORM_EN when defined.
module tb_iq_corr_accum;
    import iq_corr_pkg::*;

    localparam int LOG2_N = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clr = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_xi = '0, s_xq = '0, s_ri = '0, s_rq = '0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic signed [63:0] m_wi, m_wq;
    slot_state_t        dbg_slot;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_acc_cyc = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_wi[$];
    logic [63:0] got_wq[$];
    int          got_cyc[$];

    iq_corr_accum #(.LOG2_N(LOG2_N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_xi       (s_xi),
        .s_xq       (s_xq),
        .s_ri       (s_ri),
        .s_rq       (s_rq),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_wi       (m_wi),
        .m_wq       (m_wq),
        .o_dbg_slot (dbg_slot)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000");
        $fatal(1);
    end

    // Raw block sum to the value the output slot should hold.
    function automatic logic [63:0] exp_w(input longint raw);
`ifdef IQCORR_NORM_EN
        return 64'((raw + 2) >>> 2);
`else
        return 64'(raw);
`endif
    endfunction

    // ---------------- drivers ----------------
    task automatic send_beat(input int xi, input int xq, input int ri, input int rq);
        logic ok;
        s_xi = 16'(xi); s_xq = 16'(xq); s_ri = 16'(ri); s_rq = 16'(rq);
        s_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        last_acc_cyc = cyc;
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got s_ready=0 for 64 cycles, required acceptance");
        end
    endtask

    task automatic send_block(input int xi, input int xq, input int ri, input int rq);
        for (int b = 0; b < (1 << LOG2_N); b++) send_beat(xi, xq, ri, rq);
    endtask

    task automatic collect(input int n, input int max_cyc);
        int seen = 0;
        for (int c = 0; c < max_cyc && seen < n; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                got_wi.push_back(m_wi);
                got_wq.push_back(m_wq);
                got_cyc.push_back(cyc);
                seen++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_wi.delete();
        got_wq.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
        n_vec++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        n_vec++; if (m_wi !== 64'd0) begin n_fail++; $display("FAIL reset_m_wi: got %0d required 0", m_wi); end
        n_vec++; if (m_wq !== 64'd0) begin n_fail++; $display("FAIL reset_m_wq: got %0d required 0", m_wq); end
        n_vec++; if (dbg_slot !== EMPTY) begin n_fail++; $display("FAIL reset_slot: got %0d required EMPTY", dbg_slot); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_got();
        m_ready = 1'b1;
        exp_q.push_back(exp_w(40000)); exp_q.push_back(exp_w(0));
        fork
            send_block(100, 0, 100, 0);
            collect(1, 40);
        join
        n_vec++; if (got_wi.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d required 1", got_wi.size()); end
        if (got_wi.size() >= 1) begin
            n_vec++; if (got_wi[0] !== exp_q[0]) begin n_fail++; $display("FAIL basic_wi: got %0d required %0d", $signed(got_wi[0]), $signed(exp_q[0])); end
            n_vec++; if (got_wq[0] !== exp_q[1]) begin n_fail++; $display("FAIL basic_wq: got %0d required %0d", $signed(got_wq[0]), $signed(exp_q[1])); end
            n_vec++; if (got_cyc[0] - last_acc_cyc != 2) begin n_fail++; $display("FAIL basic_latency: got %0d required 2", got_cyc[0] - last_acc_cyc); end
        end
    endtask

    task automatic test_back_to_back();
        clear_got();
        m_ready = 1'b1;
        exp_q.push_back(exp_w(0)); exp_q.push_back(exp_w(4));
        exp_q.push_back(exp_w(0)); exp_q.push_back(exp_w(-4));
        fork
            begin
                send_block(0, 1, 1, 0);
                send_block(1, 0, 0, 1);
            end
            collect(2, 60);
        join
        n_vec++; if (got_wi.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d required 2", got_wi.size()); end
        if (got_wi.size() >= 2) begin
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (got_wi[k] !== exp_q[2*k]) begin n_fail++; $display("FAIL b2b_wi%0d: got %0d required %0d", k, $signed(got_wi[k]), $signed(exp_q[2*k])); end
                n_vec++; if (got_wq[k] !== exp_q[2*k+1]) begin n_fail++; $display("FAIL b2b_wq%0d: got %0d required %0d", k, $signed(got_wq[k]), $signed(exp_q[2*k+1])); end
            end
            n_vec++; if (got_cyc[1] - got_cyc[0] != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d required 4", got_cyc[1] - got_cyc[0]); end
        end
    endtask

    task automatic test_wide();
        clear_got();
        m_ready = 1'b1;
        exp_q.push_back(exp_w(131072)); exp_q.push_back(exp_w(64'sd8589803520));
        fork
            send_block(-32768, -32768, -32768, 32767);
            collect(1, 40);
        join
        n_vec++; if (got_wi.size() != 1) begin n_fail++; $display("FAIL wide_count: got %0d required 1", got_wi.size()); end
        if (got_wi.size() >= 1) begin
            n_vec++; if (got_wi[0] !== exp_q[0]) begin n_fail++; $display("FAIL wide_wi: got %0d required %0d", $signed(got_wi[0]), $signed(exp_q[0])); end
            n_vec++; if (got_wq[0] !== exp_q[1]) begin n_fail++; $display("FAIL wide_wq: got %0d required %0d", $signed(got_wq[0]), $signed(exp_q[1])); end
        end
    endtask

    task automatic test_stall();
        int  sent = 0;
        logic ok;
        clear_got();
        exp_q.push_back(exp_w(4)); exp_q.push_back(exp_w(0));
        m_ready = 1'b0;
        fork
            begin
                s_xi = 16'sd1; s_xq = 16'sd0; s_ri = 16'sd1; s_rq = 16'sd0;
                s_valid = 1'b1;
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    ok = s_ready;
                    if (c == 10) begin
                        n_vec++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL stall_s_ready: got %b required 0", s_ready); end
                        n_vec++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_m_valid: got %b required 1", m_valid); end
                    end
                    if (c >= 10) begin
                        n_vec++; if (m_wi !== exp_q[0]) begin n_fail++; $display("FAIL stall_hold_wi c%0d: got %0d required %0d", c, m_wi, exp_q[0]); end
                    end
                    @(posedge clk);
                    #1;
                    if (ok && s_valid) sent++;
                    if (sent == 8) s_valid = 1'b0;
                end
                m_ready = 1'b1;
            end
            collect(2, 40);
        join
        n_vec++; if (sent != 8) begin n_fail++; $display("FAIL stall_sent: got %0d required 8", sent); end
        n_vec++; if (got_wi.size() != 2) begin n_fail++; $display("FAIL stall_count: got %0d required 2", got_wi.size()); end
        if (got_wi.size() >= 2) begin
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (got_wi[k] !== exp_q[0]) begin n_fail++; $display("FAIL stall_wi%0d: got %0d required %0d", k, $signed(got_wi[k]), $signed(exp_q[0])); end
                n_vec++; if (got_wq[k] !== exp_q[1]) begin n_fail++; $display("FAIL stall_wq%0d: got %0d required %0d", k, $signed(got_wq[k]), $signed(exp_q[1])); end
            end
        end
        n_vec++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b required 0", m_valid); end
        clear_got();
        exp_q.push_back(exp_w(4));
        fork
            send_block(1, 0, 1, 0);
            collect(1, 40);
        join
        n_vec++; if (got_wi.size() != 1 || got_wi[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL stall_next_block: got %0d weights required one of %0d", got_wi.size(), $signed(exp_q[0]));
        end
    endtask

    task automatic test_clr();
        clear_got();
        m_ready = 1'b1;
        exp_q.push_back(exp_w(4)); exp_q.push_back(exp_w(0));
        fork
            begin
                send_beat(5, 5, 5, 5);
                send_beat(5, 5, 5, 5);
                s_valid = 1'b1;
                clr = 1'b1;
                @(negedge clk);
                n_vec++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL clr_s_ready: got %b required 0", s_ready); end
                @(posedge clk);
                #1;
                clr = 1'b0;
                s_valid = 1'b0;
                send_block(1, 0, 1, 0);
            end
            collect(1, 40);
        join
        n_vec++; if (got_wi.size() != 1) begin n_fail++; $display("FAIL clr_count: got %0d required 1", got_wi.size()); end
        if (got_wi.size() >= 1) begin
            n_vec++; if (got_wi[0] !== exp_q[0]) begin n_fail++; $display("FAIL clr_wi: got %0d required %0d", $signed(got_wi[0]), $signed(exp_q[0])); end
            n_vec++; if (got_wq[0] !== exp_q[1]) begin n_fail++; $display("FAIL clr_wq: got %0d required %0d", $signed(got_wq[0]), $signed(exp_q[1])); end
        end
        repeat (6) @(negedge clk);
        n_vec++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_no_extra: got %b required 0", m_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        clear_got();
        m_ready = 1'b0;
        send_block(1, 0, 1, 0);
        send_beat(1, 0, 1, 0);
        send_beat(1, 0, 1, 0);
        @(negedge clk);
        n_vec++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_full: got %b required 1", m_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_valid: got %b required 0", m_valid); end
        n_vec++; if (m_wi !== 64'd0) begin n_fail++; $display("FAIL rmid_m_wi: got %0d required 0", m_wi); end
        n_vec++; if (m_wq !== 64'd0) begin n_fail++; $display("FAIL rmid_m_wq: got %0d required 0", m_wq); end
        n_vec++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_s_ready: got %b required 1", s_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        exp_q.push_back(exp_w(24)); exp_q.push_back(exp_w(0));
        fork
            send_block(2, 0, 3, 0);
            collect(1, 40);
        join
        n_vec++; if (got_wi.size() != 1) begin n_fail++; $display("FAIL rmid_count: got %0d required 1", got_wi.size()); end
        if (got_wi.size() >= 1) begin
            n_vec++; if (got_wi[0] !== exp_q[0]) begin n_fail++; $display("FAIL rmid_wi: got %0d required %0d", $signed(got_wi[0]), $signed(exp_q[0])); end
            n_vec++; if (got_wq[0] !== exp_q[1]) begin n_fail++; $display("FAIL rmid_wq: got %0d required %0d", $signed(got_wq[0]), $signed(exp_q[1])); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wide();
        test_stall();
        test_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
